// File: rtl/proc_pkg.sv
// proc_pkg: shared types for the memory arbiter.
//   arb_owner_t : owner of the in-flight read response (none, fetch, data read).
package proc_pkg;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnDrd  = 2'd2
  } arb_owner_t;

  // A data access with any write-mask bit set is a write.
  function automatic logic is_write(input logic [31:0] wen);
    return |wen;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundles the fetch port, data port and shared memory port of mem_arb.
//   slave  : arbiter side (takes requests, drives grants/responses and memory controls).
//   master : requester/memory side (drives requests and memory read data).
interface mem_arb_if;

  // Fetch port
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  // Data port
  logic        d_req_i;
  logic [31:0] d_wen_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;

  // Shared memory port
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wen_o;
  logic [31:0] mem_din_o;
  logic [31:0] mem_dout_i;

  logic        stall_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_req_i, d_wen_i, d_addr_i, d_wdata_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_addr_o, mem_wen_o, mem_din_o,
    input  mem_dout_i,
    output stall_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_req_i, d_wen_i, d_addr_i, d_wdata_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_addr_o, mem_wen_o, mem_din_o,
    output mem_dout_i,
    input  stall_o
  );

endinterface

// File: rtl/starve_cnt.sv
// starve_cnt: counts consecutive cycles a fetch request is pending but not granted.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : fetch request pending
//   gnt_i        : fetch granted this cycle
//   hit_o        : counter has reached STARVE_MAX (fetch must win this cycle)
module starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic hit_o
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates a fetch port and a data port onto one single-cycle-latency memory.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : mem_arb_if.slave (fetch/data request ports, shared memory port, stall_o)
// Data has priority. With MEM_ARB_STARVE_EN defined, a fetch denied STARVE_MAX cycles in a
// row wins the next conflict; without it data priority is strict and STARVE_MAX is unused.
module mem_arb
  import proc_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mem_arb_if.slave  bus
);

  logic        if_gnt, d_gnt, force_if;
  arb_owner_t  owner_q, owner_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [31:0] mem_wen;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_STARVE_EN
  starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (bus.if_req_i),
    .gnt_i (if_gnt),
    .hit_o (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Grants are combinational; nothing is granted while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst_i) begin
      if (bus.if_req_i && (!bus.d_req_i || force_if)) begin
        if_gnt = 1'b1;
      end else if (bus.d_req_i) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory controls follow the grant; address and data hold when idle, write mask drops.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wen    = '0;
    owner_d    = OwnNone;
    if (if_gnt) begin
      mem_addr_d = bus.if_addr_i;
      owner_d    = OwnIf;
    end else if (d_gnt) begin
      mem_addr_d = bus.d_addr_i;
      mem_din_d  = bus.d_wdata_i;
      mem_wen    = bus.d_wen_i;
      owner_d    = is_write(bus.d_wen_i) ? OwnNone : OwnDrd;
    end
  end

  // Read data is routed to the owner of last cycle's access; the other port holds.
  always_comb begin
    if_rdata_d = (owner_q == OwnIf)  ? bus.mem_dout_i : if_rdata_q;
    d_rdata_d  = (owner_q == OwnDrd) ? bus.mem_dout_i : d_rdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q    <= OwnNone;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.if_rvalid_o = (owner_q == OwnIf);
  assign bus.d_rvalid_o  = (owner_q == OwnDrd);
  assign bus.if_rdata_o  = if_rdata_d;
  assign bus.d_rdata_o   = d_rdata_d;
  assign bus.mem_addr_o  = mem_addr_d;
  assign bus.mem_din_o   = mem_din_d;
  assign bus.mem_wen_o   = mem_wen;
  assign bus.stall_o     = !rst_i && ((bus.if_req_i && !if_gnt) || (bus.d_req_i && !d_gnt));

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb. Stimulus pushes expected read responses into a
// scoreboard queue; a negedge monitor pops and compares on every rvalid.
// Honours MEM_ARB_STARVE_EN for the starvation scenario.
module tb_mem_arb;

  typedef struct packed {
    logic        is_if;
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  rsp_t sb_q[$];

  mem_arb_if ifc ();

  mem_arb #(
    .STARVE_MAX (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0200: return 32'hCAFE_F00D;
      default:       return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  // Memory model: read data valid one cycle after the address.
  always @(posedge clk) ifc.mem_dout_i <= mem_lookup(ifc.mem_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_if, input logic [31:0] data);
    rsp_t r;
    r.is_if = is_if;
    r.data  = data;
    sb_q.push_back(r);
  endtask

  // Monitor
  always @(negedge clk) begin
    rsp_t e;
    if (ifc.if_rvalid_o && ifc.d_rvalid_o) begin
      checks++;
      failures++;
      $display("FAIL dual_rvalid: got both rvalid required at most one");
    end else if (ifc.if_rvalid_o || ifc.d_rvalid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got if=%0b d=%0b required none", ifc.if_rvalid_o,
                 ifc.d_rvalid_o);
      end else begin
        e = sb_q.pop_front();
        chk("rvalid_port_is_if", {31'd0, ifc.if_rvalid_o}, {31'd0, e.is_if});
        chk("rdata", e.is_if ? ifc.if_rdata_o : ifc.d_rdata_o, e.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_if;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    ifc.if_req_i   = 1'b1;
    ifc.if_addr_i  = 32'h100;
    ifc.d_req_i    = 1'b1;
    ifc.d_wen_i    = '0;
    ifc.d_addr_i   = 32'h200;
    ifc.d_wdata_i  = '0;
    ifc.mem_dout_i = '0;

    // Reset: requests asserted but nothing granted, all outputs at reset values.
    step();
    step();
    chk("rst_if_gnt", {31'd0, ifc.if_gnt_o}, 32'd0);
    chk("rst_d_gnt", {31'd0, ifc.d_gnt_o}, 32'd0);
    chk("rst_stall", {31'd0, ifc.stall_o}, 32'd0);
    chk("rst_mem_wen", ifc.mem_wen_o, 32'd0);
    chk("rst_mem_addr", ifc.mem_addr_o, 32'd0);
    chk("rst_mem_din", ifc.mem_din_o, 32'd0);
    chk("rst_if_rvalid", {31'd0, ifc.if_rvalid_o}, 32'd0);
    chk("rst_if_rdata", ifc.if_rdata_o, 32'd0);
    chk("rst_d_rdata", ifc.d_rdata_o, 32'd0);
    ifc.if_req_i = 1'b0;
    ifc.d_req_i  = 1'b0;
    rst = 1'b0;

    // Fetch only, 0x100.
    step();
    ifc.if_req_i  = 1'b1;
    ifc.if_addr_i = 32'h100;
    #1;
    chk("f_if_gnt", {31'd0, ifc.if_gnt_o}, 32'd1);
    chk("f_d_gnt", {31'd0, ifc.d_gnt_o}, 32'd0);
    chk("f_stall", {31'd0, ifc.stall_o}, 32'd0);
    chk("f_mem_addr", ifc.mem_addr_o, 32'h100);
    chk("f_mem_wen", ifc.mem_wen_o, 32'd0);
    push(1'b1, 32'hDEAD_BEEF);
    step();
    ifc.if_req_i = 1'b0;

    // Both: data read 0x200 wins, fetch 0x104 follows back-to-back.
    step();
    ifc.d_req_i   = 1'b1;
    ifc.d_wen_i   = '0;
    ifc.d_addr_i  = 32'h200;
    ifc.if_req_i  = 1'b1;
    ifc.if_addr_i = 32'h104;
    #1;
    chk("c_d_gnt", {31'd0, ifc.d_gnt_o}, 32'd1);
    chk("c_if_gnt", {31'd0, ifc.if_gnt_o}, 32'd0);
    chk("c_stall", {31'd0, ifc.stall_o}, 32'd1);
    chk("c_mem_addr", ifc.mem_addr_o, 32'h200);
    push(1'b0, 32'hCAFE_F00D);
    step();
    ifc.d_req_i = 1'b0;
    #1;
    chk("b2b_if_gnt", {31'd0, ifc.if_gnt_o}, 32'd1);
    chk("b2b_stall", {31'd0, ifc.stall_o}, 32'd0);
    chk("b2b_mem_addr", ifc.mem_addr_o, 32'h104);
    push(1'b1, 32'h5A5A_5B5E);
    step();
    ifc.if_req_i = 1'b0;

    // Data write 0x300: no rvalid; controls drop/hold afterwards; rdata outputs hold.
    ifc.d_req_i   = 1'b1;
    ifc.d_wen_i   = 32'hFFFF_FFFF;
    ifc.d_addr_i  = 32'h300;
    ifc.d_wdata_i = 32'h1234_5678;
    #1;
    chk("w_d_gnt", {31'd0, ifc.d_gnt_o}, 32'd1);
    chk("w_mem_wen", ifc.mem_wen_o, 32'hFFFF_FFFF);
    chk("w_mem_din", ifc.mem_din_o, 32'h1234_5678);
    chk("w_mem_addr", ifc.mem_addr_o, 32'h300);
    step();
    ifc.d_req_i = 1'b0;
    ifc.d_wen_i = '0;
    #1;
    chk("idle_mem_wen", ifc.mem_wen_o, 32'd0);
    chk("idle_mem_addr_hold", ifc.mem_addr_o, 32'h300);
    chk("idle_mem_din_hold", ifc.mem_din_o, 32'h1234_5678);
    chk("w_no_d_rvalid", {31'd0, ifc.d_rvalid_o}, 32'd0);
    chk("hold_d_rdata", ifc.d_rdata_o, 32'hCAFE_F00D);
    chk("hold_if_rdata", ifc.if_rdata_o, 32'h5A5A_5B5E);

    // Both held continuously: starvation forcing (or strict data priority).
    step();
    ifc.d_req_i   = 1'b1;
    ifc.d_wen_i   = '0;
    ifc.d_addr_i  = 32'h400;
    ifc.if_req_i  = 1'b1;
    ifc.if_addr_i = 32'h500;
    for (int c = 0; c < 6; c++) begin
      #1;
`ifdef MEM_ARB_STARVE_EN
      exp_if = (c == 4);
`else
      exp_if = 1'b0;
`endif
      chk("s_if_gnt", {31'd0, ifc.if_gnt_o}, {31'd0, exp_if});
      chk("s_d_gnt", {31'd0, ifc.d_gnt_o}, {31'd0, !exp_if});
      chk("s_stall", {31'd0, ifc.stall_o}, 32'd1);
      if (exp_if) push(1'b1, 32'h5A5A_5F5A);
      else        push(1'b0, 32'h5A5A_5E5A);
      step();
    end
    ifc.d_req_i  = 1'b0;
    ifc.if_req_i = 1'b0;

    // Reset asserted the cycle after a fetch grant: response discarded.
    step();
    ifc.if_req_i  = 1'b1;
    ifc.if_addr_i = 32'h100;
    #1;
    chk("r_if_gnt", {31'd0, ifc.if_gnt_o}, 32'd1);
    step();
    rst = 1'b1;
    ifc.if_req_i = 1'b0;
    #1;
    chk("r_if_rvalid", {31'd0, ifc.if_rvalid_o}, 32'd0);
    chk("r_if_rdata", ifc.if_rdata_o, 32'd0);
    chk("r_d_rdata", ifc.d_rdata_o, 32'd0);
    chk("r_mem_addr", ifc.mem_addr_o, 32'd0);
    chk("r_mem_din", ifc.mem_din_o, 32'd0);
    chk("r_mem_wen", ifc.mem_wen_o, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("post_rst_if_rvalid", {31'd0, ifc.if_rvalid_o}, 32'd0);
    chk("post_rst_if_rdata", ifc.if_rdata_o, 32'd0);
    step();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: STARVE_MAX, default 4, number of consecutive denied cycles of a pending fetch before fetch is forced to win.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1, asynchronous active-high reset.
REQ-005 Port if_req_i, input, 1, fetch read request; held with address stable until granted.
REQ-006 Port if_addr_i, input, 32, fetch word address.
REQ-007 Port if_gnt_o, output, 1, fetch request accepted this cycle.
REQ-008 Port if_rvalid_o, output, 1, fetch read data valid.
REQ-009 Port if_rdata_o, output, 32, fetch read data.
REQ-010 Port d_req_i, input, 1, data request; held with all fields stable until granted.
REQ-011 Port d_wen_i, input, 32, bit write mask; all-zero means read.
REQ-012 Port d_addr_i, input, 32, data address.
REQ-013 Port d_wdata_i, input, 32, write data.
REQ-014 Port d_gnt_o, output, 1, data request accepted this cycle.
REQ-015 Port d_rvalid_o, output, 1, data read data valid; never asserted for writes.
REQ-016 Port d_rdata_o, output, 32, data read data.
REQ-017 Port mem_addr_o, output, 32, shared memory address.
REQ-018 Port mem_wen_o, output, 32, shared memory bit write mask.
REQ-019 Port mem_din_o, output, 32, shared memory write data.
REQ-020 Port mem_dout_i, input, 32, shared memory read data, valid one cycle after address.
REQ-021 Port stall_o, output, 1, high when any asserted request is not granted this cycle.

Function
REQ-022 The block SHALL grant at most one requester per cycle; gnt outputs are combinational from requests and state.
REQ-023 With only one request asserted, that request SHALL be granted the same cycle.
REQ-024 With both asserted, data SHALL win unless the starvation counter equals STARVE_MAX, in which case fetch wins.
REQ-025 The starvation counter SHALL increment (saturating at STARVE_MAX) each cycle if_req_i is high and if_gnt_o low, and clear on if_gnt_o or when if_req_i is low.
REQ-026 Granted request SHALL drive mem_addr_o, mem_wen_o, mem_din_o that cycle; with no grant mem_wen_o SHALL be zero and the other memory outputs hold.
REQ-027 A registered owner state (NONE, IF, DRD) SHALL record the grant type; next cycle mem_dout_i is routed to the owner's rdata and its rvalid pulses one cycle.
REQ-028 A data write grant SHALL set owner to NONE; no rvalid follows.
REQ-029 Back-to-back grants SHALL be supported with no idle cycle; throughput one access per cycle.
REQ-030 Non-owner rdata outputs SHALL hold their last value.

Reset
REQ-031 On rst_i: owner NONE, counter 0, rvalid outputs 0, rdata outputs 0, mem_wen_o 0, mem_addr_o 0, mem_din_o 0.
REQ-032 A response outstanding when rst_i asserts SHALL be discarded; no rvalid after release.
REQ-033 While rst_i is high, gnt outputs SHALL be 0 and stall_o 0.

Configuration
REQ-034 Macro MEM_ARB_STARVE_EN defined: starvation counter and REQ-024 forcing active.
REQ-035 Macro MEM_ARB_STARVE_EN undefined: strict data priority, no counter logic, STARVE_MAX ignored.

Structure
REQ-036 Owner enumeration arb_owner_t (NONE, IF, DRD) SHALL live in proc_pkg.
REQ-037 The starvation counter SHALL be sub-module starve_cnt, instantiated only under MEM_ARB_STARVE_EN.

Verification
REQ-038 Fetch only, if_addr_i 0x100, mem_dout_i 0xDEADBEEF next cycle -> if_gnt_o same cycle, if_rvalid_o next cycle, if_rdata_o 0xDEADBEEF.
REQ-039 Both requests, data read 0x200 -> d_gnt_o, if_gnt_o 0, stall_o 1; next cycle d_rvalid_o 1 with mem_dout_i.
REQ-040 Data write 0x300 mask 0xFFFFFFFF data 0x12345678 -> mem_wen_o 0xFFFFFFFF, mem_din_o 0x12345678, no d_rvalid_o.
REQ-041 Fetch and data held high continuously, STARVE_EN, STARVE_MAX 4 -> data granted 4 cycles, fetch on 5th, counter then 0.
REQ-042 Same stimulus without MEM_ARB_STARVE_EN -> fetch never granted while d_req_i high.
REQ-043 rst_i asserted the cycle after a fetch grant -> no if_rvalid_o after release, all outputs at reset values.
